// File: rtl/calc_pkg.sv
// Shared types and encodings for the calculator operation sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_SW = 3'd1,
        ST_POP_B   = 3'd2,
        ST_POP_A   = 3'd3,
        ST_EXEC    = 3'd4,
        ST_PUSH_Y  = 3'd5
    } state_e;

    localparam logic [1:0] MEM_NOP  = 2'b00;
    localparam logic [1:0] MEM_PUSH = 2'b01;
    localparam logic [1:0] MEM_POP  = 2'b10;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b1000;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector over a vector of debounced button levels.
module btn_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] lvl,
    output logic [W-1:0] rise
);

    logic [W-1:0] lvl_q;
    logic         arm_q;

    // History clears on reset; the first cycle after reset only loads it, so a held button never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= '0;
            arm_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
            arm_q <= 1'b1;
        end
    end

    assign rise = lvl & ~lvl_q & {W{arm_q}};

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator sequencer: drives the operand memory and ALU for enter/op presses.
// Optional build macro CALC_OVF_TRAP_EN: trap ALU overflow in EXEC instead of pushing Y.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SW_W   = 16,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_enter,
    input  logic [OP_W-1:0]              btn_op,
    input  logic [SW_W-1:0]              switches,
    output logic [1:0]                   mem_cmd,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [DATA_W-1:0]            alu_a,
    output logic [DATA_W-1:0]            alu_b,
    output logic [OP_W-1:0]              alu_op,
    input  logic [DATA_W-1:0]            alu_y,
    input  logic                         alu_ovf,
    output logic [DATA_W-1:0]            result,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         err
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [OP_W-1:0]     aluop_q, aluop_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;

    logic [OP_W:0]       rise;
    logic                enter_rise;
    logic [OP_W-1:0]     op_rise;

    btn_edge #(.W(OP_W+1)) u_btn_edge (
        .clk  (clk),
        .rst  (rst),
        .lvl  ({btn_op, btn_enter}),
        .rise (rise)
    );

    assign enter_rise = rise[0];
    assign op_rise    = rise[OP_W:1];

    // Lowest-index op wins when several rise together.
    function automatic logic [OP_W-1:0] first_one(input logic [OP_W-1:0] v);
        logic [OP_W-1:0] f;
        f = '0;
        for (int i = OP_W-1; i >= 0; i--) begin
            if (v[i]) begin
                f    = '0;
                f[i] = 1'b1;
            end
        end
        return f;
    endfunction

`ifndef CALC_OVF_TRAP_EN
    logic unused_ovf;
    assign unused_ovf = alu_ovf;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wdata_d  = wdata_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        count_d  = count_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (enter_rise) begin
                    if (count_q == CNT_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        wdata_d = DATA_W'(switches);
                        state_d = ST_PUSH_SW;
                    end
                end else if (|op_rise) begin
                    if (count_q < CNT_TWO) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = first_one(op_rise);
                        state_d = ST_POP_B;
                    end
                end
            end
            ST_PUSH_SW: begin
                if (mem_ack) begin
                    count_d  = count_q + 1'b1;
                    result_d = wdata_q;
                    err_d    = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_POP_B: begin
                if (mem_ack) begin
                    b_d     = mem_rdata;
                    count_d = count_q - 1'b1;
                    state_d = ST_POP_A;
                end
            end
            ST_POP_A: begin
                if (mem_ack) begin
                    a_d     = mem_rdata;
                    count_d = count_q - 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                wdata_d = alu_y;
                state_d = ST_PUSH_Y;
`ifdef CALC_OVF_TRAP_EN
                if (alu_ovf) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_PUSH_Y: begin
                if (mem_ack) begin
                    count_d  = count_q + 1'b1;
                    result_d = wdata_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        aluop_d = (state_d == ST_EXEC) ? op_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            aluop_q  <= '0;
            wdata_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            aluop_q  <= aluop_d;
            wdata_q  <= wdata_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_PUSH_SW, ST_PUSH_Y: mem_cmd = MEM_PUSH;
            ST_POP_B, ST_POP_A:    mem_cmd = MEM_POP;
            default:               mem_cmd = MEM_NOP;
        endcase
    end

    assign mem_wdata = wdata_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = aluop_q;
    assign result    = result_q;
    assign count     = count_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Randomized self-checking bench for calc_op_sequencer against a stack-calculator model.
module tb_calc_op_sequencer;

    localparam int DATA_W = 32;
    localparam int SW_W   = 16;
    localparam int OP_W   = 4;
    localparam int DEPTH  = 4;
`ifdef CALC_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              btn_enter = 1'b0;
    logic [OP_W-1:0]   btn_op = '0;
    logic [SW_W-1:0]   switches = '0;
    logic [1:0]        mem_cmd;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] alu_a, alu_b, alu_y;
    logic [OP_W-1:0]   alu_op;
    logic              alu_ovf;
    logic [DATA_W-1:0] result;
    logic [2:0]        count;
    logic              busy, err;

    calc_op_sequencer #(.DATA_W(DATA_W), .SW_W(SW_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .btn_enter(btn_enter), .btn_op(btn_op), .switches(switches),
        .mem_cmd(mem_cmd), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_ovf(alu_ovf),
        .result(result), .count(count), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- environment: stack memory and ALU ----------------
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    int  sp = 0;
    int  wcnt = 0;
    int  wait_cfg = 0;
    bit  ovf_force = 1'b0;

    always_comb mem_ack = (mem_cmd != 2'b00) && (wcnt == wait_cfg);
    always_comb mem_rdata = (sp > 0 && sp <= DEPTH) ? mem[sp-1] : '0;

    always @(posedge clk) begin
        if (rst) begin
            sp   <= 0;
            wcnt <= 0;
        end else if (mem_ack) begin
            wcnt <= 0;
            if (mem_cmd == 2'b01 && sp < DEPTH) begin
                mem[sp] <= mem_wdata;
                sp      <= sp + 1;
            end else if (mem_cmd == 2'b10 && sp > 0) begin
                sp <= sp - 1;
            end
        end else if (mem_cmd != 2'b00) begin
            wcnt <= wcnt + 1;
        end
    end

    always_comb begin
        case (alu_op)
            4'b0001: alu_y = alu_a + alu_b;
            4'b0010: alu_y = alu_a - alu_b;
            4'b0100: alu_y = alu_a & alu_b;
            4'b1000: alu_y = alu_a | alu_b;
            default: alu_y = '0;
        endcase
        alu_ovf = ovf_force && (alu_op != '0);
    end

    // ---------------- monitor ----------------
    int exec_cnt = 0, cmd_cycles = 0, viol = 0;
    logic [DATA_W-1:0] mon_a = '0, mon_b = '0;
    logic [OP_W-1:0]   mon_op = '0;
    logic [1:0] prev_cmd = 2'b00;
    logic       prev_ack = 1'b0;
    bit         rst_guard = 1'b1;

    always @(negedge clk) begin
        if (alu_op != '0) begin
            exec_cnt++;
            mon_a  = alu_a;
            mon_b  = alu_b;
            mon_op = alu_op;
        end
        if (mem_cmd != 2'b00) cmd_cycles++;
        if (!rst_guard && prev_cmd != 2'b00 && !prev_ack && mem_cmd != prev_cmd) viol++;
        prev_cmd = mem_cmd;
        prev_ack = mem_ack;
    end

    // ---------------- checking ----------------
    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: a plain calculator stack ----------------
    logic [DATA_W-1:0] mq[$];
    bit                m_err = 1'b0;
    logic [DATA_W-1:0] m_result = '0;

    function automatic logic [DATA_W-1:0] ref_alu(input int idx, input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (idx)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic do_reset();
        rst_guard = 1'b1;
        rst = 1'b1;
        btn_enter = 1'b0;
        btn_op = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_err = 1'b0;
        m_result = '0;
        repeat (2) @(negedge clk);
        rst_guard = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(mq.size()));
        check({tag, "_result"}, result, m_result);
        check({tag, "_err"}, 32'(err), 32'(m_err));
        check({tag, "_memdepth"}, 32'(sp), 32'(mq.size()));
    endtask

    // One press: enter level and/or op mask; model decides the winner and expected timing.
    task automatic press(input string tag, input bit ent, input logic [OP_W-1:0] opm,
                         input logic [SW_W-1:0] sw, input bit inject);
        int exp_busy, exp_exec, idx, n, e0, c0;
        logic [DATA_W-1:0] a, b, y;
        exp_busy = 0;
        exp_exec = 0;
        idx = -1;
        a = '0;
        b = '0;
        if (ent) begin
            if (mq.size() == DEPTH) m_err = 1'b1;
            else begin
                mq.push_back(DATA_W'(sw));
                m_result = DATA_W'(sw);
                m_err = 1'b0;
                exp_busy = 1 + wait_cfg;
            end
        end else if (opm != '0) begin
            for (int i = OP_W-1; i >= 0; i--) if (opm[i]) idx = i;
            if (mq.size() < 2) m_err = 1'b1;
            else begin
                b = mq.pop_back();
                a = mq.pop_back();
                y = ref_alu(idx, a, b);
                exp_exec = 1;
                if (TRAP && ovf_force) begin
                    m_err = 1'b1;
                    exp_busy = 2 * (1 + wait_cfg) + 1;
                end else begin
                    mq.push_back(y);
                    m_result = y;
                    exp_busy = 3 * (1 + wait_cfg) + 1;
                end
            end
        end
        e0 = exec_cnt;
        c0 = cmd_cycles;
        switches = sw;
        btn_enter = ent;
        btn_op = opm;
        @(negedge clk);
        btn_enter = 1'b0;
        btn_op = '0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (inject && n == 1) btn_enter = 1'b1;
            if (inject && n == 2) btn_enter = 1'b0;
            @(negedge clk);
        end
        btn_enter = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        check({tag, "_exec"}, 32'(exec_cnt - e0), 32'(exp_exec));
        if (exp_busy == 0) check({tag, "_no_mem_cmd"}, 32'(cmd_cycles - c0), 32'd0);
        if (exp_exec == 1) begin
            check({tag, "_alu_a"}, mon_a, a);
            check({tag, "_alu_b"}, mon_b, b);
            check({tag, "_alu_op"}, 32'(mon_op), 32'(1 << idx));
        end
        check_state(tag);
        @(negedge clk);
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_cmd", 32'(mem_cmd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_aluop", 32'(alu_op), 32'd0);
        check_state("rst");

        // zero-wait ADD: 7 + 3
        wait_cfg = 0;
        press("t1_e7", 1'b1, '0, 16'h0007, 1'b0);
        press("t1_e3", 1'b1, '0, 16'h0003, 1'b0);
        press("t1_add", 1'b0, 4'b0001, '0, 1'b0);
        check("t1_a7", mon_a, 32'd7);
        check("t1_b3", mon_b, 32'd3);
        check("t1_y", result, 32'h0000000A);
        check("t1_cnt", 32'(count), 32'd1);

        // op on empty and single-entry memory, then enter clears err
        do_reset();
        press("t2_op_empty", 1'b0, 4'b0010, '0, 1'b0);
        check("t2_err", 32'(err), 32'd1);
        press("t2_enter", 1'b1, '0, 16'hBEEF, 1'b0);
        check("t2_err_clr", 32'(err), 32'd0);
        press("t2_op_one", 1'b0, 4'b1000, '0, 1'b0);

        // fill to DEPTH, fifth enter overflows
        do_reset();
        for (int i = 0; i < 5; i++) press("t3_fill", 1'b1, '0, 16'(16'h0100 + i), 1'b0);
        check("t3_cnt", 32'(count), 32'd4);
        check("t3_err", 32'(err), 32'd1);

        // same-cycle priority
        press("t3_sub", 1'b0, 4'b0110, '0, 1'b0);
        press("t3_prio_enter", 1'b1, 4'b0001, 16'h1234, 1'b0);

        // slow memory with an enter pulse while busy
        wait_cfg = 3;
        press("t4_op", 1'b0, 4'b0100, '0, 1'b1);
        press("t4_enter", 1'b1, '0, 16'hFFFF, 1'b1);

        // reset while in POP_A
        do_reset();
        press("t5_e5", 1'b1, '0, 16'h0005, 1'b0);
        press("t5_e9", 1'b1, '0, 16'h0009, 1'b0);
        btn_op = 4'b0001;
        begin
            int n;
            n = 0;
            @(negedge clk);
            btn_op = '0;
            while (count != 3'd1 && n < 100) begin
                n++;
                @(negedge clk);
            end
            check("t5_reach_popa", 32'(count), 32'd1);
        end
        rst_guard = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_err = 1'b0;
        m_result = '0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_cmd", 32'(mem_cmd), 32'd0);
        check("t5_a", alu_a, 32'd0);
        check("t5_b", alu_b, 32'd0);
        check("t5_wdata", mem_wdata, 32'd0);
        check_state("t5");
        repeat (2) @(negedge clk);
        rst_guard = 1'b0;

        // overflow flag in EXEC (trapped only when the trap build is enabled)
        wait_cfg = 1;
        press("t6_e1", 1'b1, '0, 16'h7FFF, 1'b0);
        press("t6_e2", 1'b1, '0, 16'h0001, 1'b0);
        ovf_force = 1'b1;
        press("t6_ovf", 1'b0, 4'b0001, '0, 1'b0);
        ovf_force = 1'b0;

        // randomized sequence
        do_reset();
        for (int k = 0; k < 80; k++) begin
            wait_cfg = $urandom_range(0, 2);
            ovf_force = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) < 5)
                press("rnd_enter", 1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 1'b0);
            else
                press("rnd_op", 1'b0, 4'($urandom_range(1, 15)), 16'($urandom), 1'b0);
        end
        ovf_force = 1'b0;

        check("protocol", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
